uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

UART receive path with a small elastic buffer and RTS flow-control output for the SoC's serial console. It deserialises 8N1 frames from `uart_rxd` and presents bytes on a valid/ready stream to the UART peripheral. It drives `uart_rts` so the host pauses before the buffer overflows. It is the receive-side counterpart to the transmitter inside `fpga_top`, and is instantiated in `fpga_top` in place of the bare receiver.

## Interface

Parameters:
- `DIV`, 16: clock cycles per bit; must be ≥ 4.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `RTS_THRESH`, 6: `uart_rts` deasserts when occupancy ≥ this value; 1 ≤ `RTS_THRESH` ≤ `DEPTH`.

Ports:
- `clk`, input, 1: the single clock; all logic runs on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `uart_rxd`, input, 1: serial line, idle high, asynchronous to `clk`.
- `uart_rts`, output, 1: high means the host may send.
- `rx_data`, output, 8: head-of-FIFO byte (show-ahead).
- `rx_valid`, output, 1: FIFO is non-empty.
- `rx_ready`, input, 1: consumer accepts the head byte when `rx_valid & rx_ready`.
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

Synchroniser:
- `uart_rxd` passes through two flops, both resetting to 1. The synchronised value `rxs` feeds all logic.

Receiver FSM (states IDLE, START, DATA, STOP, BREAK):
- **IDLE**: a falling edge of `rxs` loads the bit counter with `DIV/2 - 1` and enters START.
- **START**: at counter expiry, sample `rxs`.
  - 0: load `DIV - 1`, clear the bit index, enter DATA.
  - 1: treat as a glitch; return to IDLE, push nothing, flag nothing.
- **DATA**: at each counter expiry, shift `rxs` into the shift register LSB-first and reload `DIV - 1`. After the 8th bit, enter STOP.
- **STOP**: at counter expiry, sample `rxs`.
  - 1: push the byte and return to IDLE.
  - 0: pulse `frame_err`, discard the byte, enter BREAK.
- **BREAK**: stay until `rxs` = 1, then go to IDLE. This keeps a held-low line from producing repeated frames.

FIFO:
- `DEPTH` entries with `log2(DEPTH)`-bit read and write pointers and a `log2(DEPTH)+1`-bit count. Pointers wrap modulo `DEPTH`.
- pop = `rx_valid & rx_ready`.
- A push is accepted if count < `DEPTH`, or if a pop occurs in the same cycle.
- Otherwise the push is dropped: `overrun` pulses and the FIFO state is unchanged.
- Simultaneous push and pop leaves count unchanged and advances both pointers.
- `rx_data` equals `mem[rd_ptr]`. Its value is don't-care while `rx_valid` is 0.

Flow control:
- `uart_rts` is registered: `uart_rts <= (count_next < RTS_THRESH)`.
- A frame already in flight always completes, whatever `uart_rts` does.

## Timing

Reset values:
- FSM in IDLE; counters, pointers and count all 0.
- `rx_valid` 0, `frame_err` 0, `overrun` 0.
- `uart_rts` 1.
- `rx_data` don't-care.
- Asserting `rst` mid-frame abandons the frame. Nothing is pushed and no error is flagged.

Latency and pulses:
- Input latency is 2 cycles through the synchroniser. The start edge is detected on the 3rd clock after the line falls.
- Each data bit is sampled `DIV/2 + k·DIV` cycles after start-edge detection, for k = 1..8. The stop bit is sampled at k = 9.
- The push takes effect on the clock edge that samples the stop bit. `rx_valid` rises in the same cycle as the new count (registered, 1 cycle after the sample).
- `frame_err` and `overrun` are registered and high for exactly one cycle. Both are aligned with the cycle in which the push or discard is decided.
- `uart_rts` changes 1 cycle after the count crosses `RTS_THRESH`.

Boundaries:
- Back-to-back frames are handled: a new falling edge is accepted in the cycle after STOP returns to IDLE.
- Full FIFO with a simultaneous pop: the push succeeds and no `overrun` pulse occurs.

## Test plan

1. **Single byte**: `DIV`=16; send 0xA5 as 8N1 with `rx_ready`=1.
   - `rx_valid` goes high for 1 cycle with `rx_data`=0xA5.
   - `frame_err`=0, `overrun`=0.
2. **Glitch rejection**: hold `uart_rxd` low for 4 cycles, then high.
   - No push, no `frame_err`; FSM back in IDLE.
   - A following 0x3C is received correctly.
3. **Framing error**: send 0x55 with the stop bit low, then hold the line low for 40 bits, then release.
   - Exactly one `frame_err` pulse and no push.
   - The next frame, 0x81, is received correctly.
4. **Flow control and overrun**: `DEPTH`=8, `RTS_THRESH`=6, `rx_ready`=0; send 0x00..0x08.
   - `uart_rts` falls one cycle after the 6th push.
   - The 9th byte produces one `overrun` pulse.
   - Draining returns 0x00..0x07 in order; `uart_rts` rises once count < 6.
5. **Full with simultaneous pop**: FIFO full; assert `rx_ready` for exactly the stop-sample cycle of byte 0x77.
   - No `overrun`; count stays at 8.
   - 0x77 is the last byte read out.
6. **Reset mid-frame**: assert `rst` during data bit 4.
   - All outputs take their reset values; the FIFO is empty.
   - The next full frame, 0xC3, is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// 8N1 UART receiver for the serial console. Deserialised bytes land in a
// small show-ahead FIFO drained over a valid/ready stream, and uart_rts is
// dropped as the FIFO fills so the host pauses before bytes are lost.

module uart_rx_fifo #(
    parameter int DIV        = 16,  // clock cycles per bit, >= 4
    parameter int DEPTH      = 8,   // FIFO entries, power of two, >= 2
    parameter int RTS_THRESH = 6    // uart_rts low when occupancy >= this
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic       uart_rts,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV);

    // Bit-timer reload values: half a bit to land mid start bit, then whole bits.
    localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);

    // Occupancy limits expressed in the count's own width.
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] RTS_LIMIT = (AW + 1)'(RTS_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_e;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    // Two-flop synchroniser; both stages reset high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rx_meta_q <= uart_rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e     state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;

    logic bit_tick;     // bit timer has expired this cycle
    logic stop_sample;  // this edge samples the stop bit
    logic push;         // a complete, well-framed byte is ready in shift_q

    assign bit_tick    = (bit_cnt_q == '0);
    assign stop_sample = (state_q == S_STOP) && bit_tick;
    assign push        = stop_sample && rxs_q;

    // Frame sequencing: start detection, mid-bit sampling, stop check and break hold-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                // IDLE is only ever entered with the line high, so a low level here is a falling edge.
                S_IDLE: begin
                    if (!rxs_q) begin
                        bit_cnt_q <= HALF_RELOAD;
                        state_q   <= S_START;
                    end
                end

                // Mid start bit: still low means a real frame, high means it was a glitch.
                S_START: begin
                    if (bit_tick) begin
                        if (!rxs_q) begin
                            bit_cnt_q <= FULL_RELOAD;
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                // Data bits arrive LSB first, so each new bit enters at the top and shifts down.
                S_DATA: begin
                    if (bit_tick) begin
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_cnt_q <= FULL_RELOAD;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                // Good stop bit: the FIFO takes the byte on this same edge via push.
                S_STOP: begin
                    if (bit_tick) begin
                        if (rxs_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                // A held-low line must return high before another start bit is believed.
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overrun_q;
    logic          uart_rts_q;

    logic pop;
    logic push_ok;

    // Pointer and occupancy update; a full FIFO still accepts a byte when the head leaves this cycle.
    always_comb begin
        // NOTE: every signal gets a default before any condition so no latch is inferred.
        pop      = (count_q != '0) && rx_ready;
        push_ok  = push && ((count_q < DEPTH_CNT) || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO control state, overrun pulse and registered flow control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            uart_rts_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= push && !push_ok;
            uart_rts_q <= (count_d < RTS_LIMIT);
        end
    end

    // Byte storage written at the stop-bit edge.
    // NOTE: the array has no reset; its contents are only observed while rx_valid is high.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = (count_q != '0);
    assign uart_rts  = uart_rts_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo: frames are driven bit by bit, expected bytes
// go into a scoreboard queue as they are sent and are compared as the stream
// hands them out. Pulse outputs are tallied per cycle and checked as deltas.

module tb_uart_rx_fifo;

    localparam int DIV        = 16;
    localparam int DEPTH      = 8;
    localparam int RTS_THRESH = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       uart_rts;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .DIV        (DIV),
        .DEPTH      (DEPTH),
        .RTS_THRESH (RTS_THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .uart_rts  (uart_rts),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Bookkeeping
    int tests = 0;
    int fails = 0;
    int n_pops = 0, n_valid = 0, n_ferr = 0, n_ovr = 0;
    int pops0 = 0, valid0 = 0, ferr0 = 0, ovr0 = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_byte;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        pops0  = n_pops;
        valid0 = n_valid;
        ferr0  = n_ferr;
        ovr0   = n_ovr;
    endtask

    // Drive one 8N1 frame. The line is left at the stop-bit level afterwards.
    // pulse_at >= 0 makes rx_ready high only during that cycle of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pulse_at);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rxd = bits[0];
            for (int c = 0; c < DIV; c++) begin
                if (pulse_at >= 0) rx_ready = ((b * DIV + c) == pulse_at);
                tick();
            end
            bits = bits >> 1;
        end
    endtask

    // Output monitor on the falling edge: tally pulses and score popped bytes.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (rx_valid)  n_valid++;
            if (rx_valid && rx_ready) begin
                n_pops++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_byte = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(exp_byte));
                end
                last_byte = rx_data;
            end
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- Reset state ----------------
        rst = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b0;
        repeat (3) tick();
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_uart_rts",  32'(uart_rts),  32'd1);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // ---------------- 1: single byte ----------------
        rx_ready = 1'b1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        repeat (8) tick();
        check("t1_pops",         n_pops - pops0,   1);
        check("t1_valid_cycles", n_valid - valid0, 1);
        check("t1_frame_err",    n_ferr - ferr0,   0);
        check("t1_overrun",      n_ovr - ovr0,     0);
        check("t1_sb_empty",     exp_q.size(),     0);

        // ---------------- 2: glitch rejection ----------------
        snap();
        uart_rxd = 1'b0;
        repeat (4) tick();
        uart_rxd = 1'b1;
        repeat (2 * DIV) tick();
        check("t2_glitch_pops", n_pops - pops0, 0);
        check("t2_glitch_ferr", n_ferr - ferr0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        repeat (8) tick();
        check("t2_next_pops", n_pops - pops0, 1);
        check("t2_sb_empty",  exp_q.size(),   0);

        // ---------------- 3: framing error and break ----------------
        snap();
        send_frame(8'h55, 1'b0, -1);
        repeat (40 * DIV) tick();
        uart_rxd = 1'b1;
        repeat (2 * DIV) tick();
        check("t3_ferr_pulses", n_ferr - ferr0, 1);
        check("t3_pops",        n_pops - pops0, 0);
        check("t3_overrun",     n_ovr - ovr0,   0);
        snap();
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        repeat (8) tick();
        check("t3_next_pops", n_pops - pops0, 1);
        check("t3_next_ferr", n_ferr - ferr0, 0);
        check("t3_sb_empty",  exp_q.size(),   0);

        // ---------------- 4: flow control and overrun ----------------
        rx_ready = 1'b0;
        snap();
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, -1);
            if (i == RTS_THRESH - 2) check("t4_rts_below_thresh", 32'(uart_rts), 32'd1);
            if (i == RTS_THRESH - 1) check("t4_rts_at_thresh",    32'(uart_rts), 32'd0);
        end
        repeat (4) tick();
        check("t4_overrun_pulses", n_ovr - ovr0,     1);
        check("t4_frame_err",      n_ferr - ferr0,   0);
        check("t4_valid_full",     32'(rx_valid),    32'd1);
        check("t4_rts_full",       32'(uart_rts),    32'd0);
        check("t4_no_pops",        n_pops - pops0,   0);
        for (int i = 0; i < DEPTH; i++) begin
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            check("t4_rts_drain", 32'(uart_rts), 32'((DEPTH - 1 - i) < RTS_THRESH));
            tick();
        end
        check("t4_drain_pops", n_pops - pops0, DEPTH);
        check("t4_valid_empty", 32'(rx_valid), 32'd0);
        check("t4_sb_empty",    exp_q.size(),  0);

        // ---------------- 5: full FIFO with simultaneous pop ----------------
        rx_ready = 1'b0;
        snap();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, -1);
        end
        repeat (4) tick();
        check("t5_full_valid",   32'(rx_valid), 32'd1);
        check("t5_full_rts",     32'(uart_rts), 32'd0);
        check("t5_fill_overrun", n_ovr - ovr0,  0);
        snap();
        exp_q.push_back(8'h77);
        // Stop bit of this frame is sampled on the 155th edge after the line falls.
        send_frame(8'h77, 1'b1, 10 * DIV - 6);
        repeat (4) tick();
        check("t5_overrun",     n_ovr - ovr0,   0);
        check("t5_stop_pop",    n_pops - pops0, 1);
        check("t5_still_valid", 32'(rx_valid),  32'd1);
        snap();
        rx_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        rx_ready = 1'b0;
        check("t5_drain_count", n_pops - pops0,  DEPTH);
        check("t5_last_byte",   32'(last_byte),  32'h77);
        check("t5_sb_empty",    exp_q.size(),    0);
        check("t5_valid_empty", 32'(rx_valid),   32'd0);

        // ---------------- 6: reset mid-frame ----------------
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        repeat (4) tick();
        check("t6_prefill_valid", 32'(rx_valid), 32'd1);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hF0, 1'b0};
            // Start bit plus data bits 0..3, then half of data bit 4.
            for (int b = 0; b < 6; b++) begin
                uart_rxd = bits[0];
                for (int c = 0; c < ((b == 5) ? DIV / 2 : DIV); c++) tick();
                bits = bits >> 1;
            end
        end
        snap();
        rst = 1'b1;
        uart_rxd = 1'b1;
        tick();
        check("t6_rst_valid",     32'(rx_valid),  32'd0);
        check("t6_rst_rts",       32'(uart_rts),  32'd1);
        check("t6_rst_frame_err", 32'(frame_err), 32'd0);
        check("t6_rst_overrun",   32'(overrun),   32'd0);
        tick();
        rst = 1'b0;
        repeat (2 * DIV) tick();
        check("t6_after_ferr",  n_ferr - ferr0, 0);
        check("t6_after_pops",  n_pops - pops0, 0);
        check("t6_after_valid", 32'(rx_valid),  32'd0);
        rx_ready = 1'b1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1);
        repeat (8) tick();
        check("t6_next_pops", n_pops - pops0, 1);
        check("t6_sb_empty",  exp_q.size(),   0);
        check("t6_ovr_total", n_ovr - ovr0,   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
